// File: rtl/cordic_ctrl_pkg.sv
// Shared types and default widths for the CORDIC sweep sequencer.
package cordic_ctrl_pkg;

    localparam int FREQ_W  = 12;
    localparam int DWELL_W = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Dwell counter reload: a programmed dwell of 0 behaves like 1.
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

endpackage

// File: rtl/cordic_sweep_ctrl_if.sv
// Configuration and status bundle between the config source and the sweep sequencer.
interface cordic_sweep_ctrl_if #(
    parameter int FREQ_W  = cordic_ctrl_pkg::FREQ_W,
    parameter int DWELL_W = cordic_ctrl_pkg::DWELL_W
);
    logic               start;
    logic               stop;
    logic [FREQ_W-1:0]  f_start;
    logic [FREQ_W-1:0]  f_stop;
    logic [FREQ_W-1:0]  f_step;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
    logic               wave_cfg;
    logic [FREQ_W-1:0]  freq;
    logic               waveform_sel;
    logic               freq_tick;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, f_start, f_stop, f_step, dwell, cont, wave_cfg,
        input  freq, waveform_sel, freq_tick, busy, done, err
    );

    modport slave (
        input  start, stop, f_start, f_stop, f_step, dwell, cont, wave_cfg,
        output freq, waveform_sel, freq_tick, busy, done, err
    );
endinterface

// File: rtl/dwell_counter.sv
// Down-counter timing how long each frequency step is held.
module dwell_counter #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);
    logic [DWELL_W-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Frequency sweep sequencer driving the CORDIC tone generator's freq word.
module cordic_sweep_ctrl
    import cordic_ctrl_pkg::*;
(
    input  logic clk1,
    input  logic reset,
    cordic_sweep_ctrl_if.slave bus
);
    state_t              r_state, w_state_next;
    dir_t                r_dir, w_dir_next;
    logic                r_start_pend;
    logic [FREQ_W-1:0]   r_sh_f_start, r_sh_f_stop, r_sh_f_step;
    logic [DWELL_W-1:0]  r_sh_dwell;
    logic                r_sh_cont, r_sh_wave;
    logic [FREQ_W-1:0]   r_freq, w_freq_next;
    logic                r_wave, w_wave_next;
    logic                r_err, w_err_next;
    logic                r_tick, r_busy, r_done;
    logic                w_capture, w_cfg_bad;
    logic                w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [DWELL_W-1:0]  w_cnt_reload;
    logic [FREQ_W:0]     w_up_sum, w_dn_diff;
    logic [FREQ_W-1:0]   w_up_val, w_dn_val;

    // A start is registered together with the config so the validity check
    // works from stable shadow copies; stop in the same cycle vetoes it.
    assign w_capture    = (r_state == IDLE) && bus.start && !bus.stop && !r_start_pend;
    assign w_cfg_bad    = (r_sh_f_step == '0) || (r_sh_f_start > r_sh_f_stop);
    assign w_cnt_reload = dwell_reload(r_sh_dwell);

    // Saturating step arithmetic one bit wider so neither direction wraps.
    assign w_up_sum  = {1'b0, r_freq} + {1'b0, r_sh_f_step};
    assign w_dn_diff = {1'b0, r_freq} - {1'b0, r_sh_f_step};
    assign w_up_val  = (w_up_sum > {1'b0, r_sh_f_stop}) ? r_sh_f_stop : w_up_sum[FREQ_W-1:0];
    assign w_dn_val  = (w_dn_diff[FREQ_W] || (w_dn_diff < {1'b0, r_sh_f_start}))
                       ? r_sh_f_start : w_dn_diff[FREQ_W-1:0];

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk        (clk1),
        .srst       (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_reload),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Shadow config and pending-start flag, updated only from IDLE.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_start_pend <= 1'b0;
            r_sh_f_start <= '0;
            r_sh_f_stop  <= '0;
            r_sh_f_step  <= '0;
            r_sh_dwell   <= '0;
            r_sh_cont    <= 1'b0;
            r_sh_wave    <= 1'b0;
        end else begin
            r_start_pend <= w_capture;
            if (w_capture) begin
                r_sh_f_start <= bus.f_start;
                r_sh_f_stop  <= bus.f_stop;
                r_sh_f_step  <= bus.f_step;
                r_sh_dwell   <= bus.dwell;
                r_sh_cont    <= bus.cont;
                r_sh_wave    <= bus.wave_cfg;
            end
        end
    end

    // State register.
    always_ff @(posedge clk1) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state and datapath updates for each sweep phase.
    always_comb begin
        w_state_next = r_state;
        w_freq_next  = r_freq;
        w_wave_next  = r_wave;
        w_dir_next   = r_dir;
        w_err_next   = r_err;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_start_pend && !bus.stop) begin
                    if (w_cfg_bad) begin
                        w_err_next   = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_err_next   = 1'b0;
                        w_state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.stop) begin
                    w_state_next = IDLE;
                end else begin
                    w_freq_next  = r_sh_f_start;
                    w_wave_next  = r_sh_wave;
                    w_dir_next   = UP;
                    w_cnt_load   = 1'b1;
                    w_state_next = DWELL;
                end
            end
            DWELL: begin
                if (bus.stop)        w_state_next = IDLE;
                else if (w_cnt_zero) w_state_next = STEP;
                else                 w_cnt_dec    = 1'b1;
            end
            STEP: begin
                if (bus.stop) begin
                    w_state_next = IDLE;
                end else if ((r_dir == UP) && (r_freq == r_sh_f_stop) && !r_sh_cont) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_load   = 1'b1;
                    w_state_next = DWELL;
                    if (r_dir == UP) begin
                        if (r_freq != r_sh_f_stop) begin
                            w_freq_next = w_up_val;
                        end else begin
                            w_dir_next  = DOWN;
                            w_freq_next = w_dn_val;
                        end
                    end else begin
                        if (r_freq != r_sh_f_start) begin
                            w_freq_next = w_dn_val;
                        end else begin
                            w_dir_next  = UP;
                            w_freq_next = w_up_val;
                        end
                    end
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered outputs; busy/done decode the state being entered.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_freq <= '0;
            r_wave <= 1'b0;
            r_dir  <= UP;
            r_err  <= 1'b0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_freq <= w_freq_next;
            r_wave <= w_wave_next;
            r_dir  <= w_dir_next;
            r_err  <= w_err_next;
            r_tick <= (w_freq_next != r_freq);
            r_busy <= (w_state_next == LOAD) || (w_state_next == DWELL) || (w_state_next == STEP);
            r_done <= (w_state_next == DONE);
        end
    end

    assign bus.freq         = r_freq;
    assign bus.waveform_sel = r_wave;
    assign bus.freq_tick    = r_tick;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Bench for cordic_sweep_ctrl: per-cycle comparison against a list-based sweep model.
module tb_cordic_sweep_ctrl;
    import cordic_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cordic_sweep_ctrl_if bus ();

    cordic_sweep_ctrl dut (
        .clk1  (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic ws, tk, bz, dn, er;
    } obs_t;

    int checks = 0;
    int errors = 0;

    // Outputs visible before the current run starts.
    int pf = 0, pw = 0, pe = 0;

    // Current run description.
    int c_fs, c_fe, c_st, c_dw, c_cont, c_wave, c_valid, c_veto, c_hold, c_last, c_kend;
    int vals[$];

    // Sweep as a list of values: the up ramp, then alternating down/up ramps.
    function automatic void build_vals(input int n);
        int up_l[$];
        int dn_l[$];
        int v;
        vals.delete();
        v = c_fs;
        forever begin
            up_l.push_back(v);
            if (v >= c_fe) break;
            v = (v + c_st > c_fe) ? c_fe : v + c_st;
        end
        v = c_fe;
        forever begin
            dn_l.push_back(v);
            if (v <= c_fs) break;
            v = (v - c_st < c_fs) ? c_fs : v - c_st;
        end
        vals = up_l;
        if (c_cont != 0) begin
            if (c_fs == c_fe) begin
                while (vals.size() < n) vals.push_back(c_fs);
            end else begin
                while (vals.size() < n) begin
                    for (int j = 1; j < dn_l.size(); j++) vals.push_back(dn_l[j]);
                    for (int j = 1; j < up_l.size(); j++) vals.push_back(up_l[j]);
                end
            end
        end
    endfunction

    // Expected outputs in cycle k, where start was driven in cycle 0.
    function automatic obs_t expect_at(input int k);
        obs_t e;
        int i;
        int prev;
        e.freq = FREQ_W'(pf);
        e.ws   = pw[0];
        e.tk   = 1'b0;
        e.bz   = 1'b0;
        e.dn   = 1'b0;
        e.er   = pe[0];
        if (c_veto != 0) return e;
        if (c_valid == 0) begin
            e.dn = (k == 2);
            if (k >= 2) e.er = 1'b1;
            return e;
        end
        if (k >= 2) begin
            e.er = 1'b0;
            e.bz = (c_cont != 0) || (k < c_kend);
            e.dn = (k == c_kend);
        end
        if (k >= 3) begin
            e.ws = c_wave[0];
            i = (k - 3) / c_hold;
            if (c_cont == 0 && i > c_last) begin
                i = c_last;
            end else if ((k - 3) % c_hold == 0) begin
                prev = (i == 0) ? pf : vals[i-1];
                e.tk = (vals[i] != prev);
            end
            e.freq = FREQ_W'(vals[i]);
        end
        return e;
    endfunction

    // One sweep: start in cycle 0, optional stop (ks), mid-sweep start (mk),
    // reset (rk) or start+stop veto; config inputs are scrambled after cycle 0.
    task automatic run(input string tag, input int fs, input int fe, input int st,
                       input int dw, input int cont, input int wave,
                       input int ks, input int mk, input int rk, input int veto);
        int hz;
        obs_t e, got;
        c_fs = fs; c_fe = fe; c_st = st; c_dw = dw; c_cont = cont; c_wave = wave;
        c_valid = (st != 0 && fs <= fe) ? 1 : 0;
        c_veto  = veto;
        c_hold  = ((dw == 0) ? 1 : dw) + 1;
        if (c_valid != 0 && veto == 0) build_vals(64);
        else vals.delete();
        c_last = vals.size() - 1;
        if (c_valid == 0)     c_kend = 2;
        else if (cont != 0)   c_kend = 1 << 30;
        else                  c_kend = 3 + (c_last + 1) * c_hold;
        if (ks > 0)                          hz = ks + 3;
        else if (rk > 0)                     hz = rk + 3;
        else if (c_valid != 0 && veto == 0)  hz = c_kend + 2;
        else                                 hz = 5;
        e = '0;
        for (int k = 0; k <= hz; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.f_start  = FREQ_W'(fs);
                bus.f_stop   = FREQ_W'(fe);
                bus.f_step   = FREQ_W'(st);
                bus.dwell    = DWELL_W'(dw);
                bus.cont     = cont[0];
                bus.wave_cfg = wave[0];
                bus.start    = 1'b1;
                bus.stop     = (veto != 0);
            end else begin
                bus.f_start  = FREQ_W'($urandom);
                bus.f_stop   = FREQ_W'($urandom);
                bus.f_step   = FREQ_W'($urandom);
                bus.dwell    = DWELL_W'($urandom_range(0, 5));
                bus.cont     = 1'($urandom);
                bus.wave_cfg = 1'($urandom);
                bus.start    = (k == mk);
                bus.stop     = (k == ks);
            end
            reset = (rk > 0 && k == rk);
            @(negedge clk);
            if (rk > 0 && k > rk) begin
                e = '0;
            end else if (ks > 0 && k > ks) begin
                e = expect_at(ks);
                e.tk = 1'b0;
                e.bz = 1'b0;
                e.dn = 1'b0;
            end else begin
                e = expect_at(k);
            end
            got = {bus.freq, bus.waveform_sel, bus.freq_tick, bus.busy, bus.done, bus.err};
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL %s k=%0d got f=%0d ws=%b tk=%b bz=%b dn=%b er=%b want f=%0d ws=%b tk=%b bz=%b dn=%b er=%b",
                       tag, k, got.freq, got.ws, got.tk, got.bz, got.dn, got.er,
                       e.freq, e.ws, e.tk, e.bz, e.dn, e.er);
            end
        end
        pf = int'(e.freq);
        pw = int'(e.ws);
        pe = int'(e.er);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset     = 1'b0;
        $display("run %s fs=%0d fe=%0d step=%0d dwell=%0d cont=%0d cycles=%0d freq_end=%0d", tag, fs, fe, st, dw, cont, hz + 1, pf);
    endtask

    initial begin
        obs_t got;
        int fs, fe, st, dw, cn, ks;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.f_start  = '0;
        bus.f_stop   = '0;
        bus.f_step   = '0;
        bus.dwell    = '0;
        bus.cont     = 1'b0;
        bus.wave_cfg = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {bus.freq, bus.waveform_sel, bus.freq_tick, bus.busy, bus.done, bus.err};
        checks++;
        assert (got === obs_t'(0)) else begin
            errors++;
            $error("FAIL reset_state got %h want 0", got);
        end
        $display("reset state observed %h", got);
        @(posedge clk);
        #1 reset = 1'b0;

        //   tag          fs    fe    st    dw cont wave ks mk rk veto
        run("oneshot",    100,  130,  10,   4, 0,   1,   0, 0, 0, 0);
        run("cont_stop",  100,  130,  10,   4, 1,   0,  40, 0, 0, 0);
        run("clamp",      100,  125,  10,   0, 0,   1,   0, 0, 0, 0);
        run("bad_step",    50,   60,   0,   2, 0,   0,   0, 0, 0, 0);
        run("clear_err",    5,    5,   1,   1, 0,   0,   0, 0, 0, 0);
        run("bad_order",  300,  200,   5,   1, 0,   1,   0, 0, 0, 0);
        run("veto",       400,  500,  10,   1, 0,   1,   0, 0, 0, 1);
        run("mid_start",  200,  260,  20,   2, 0,   1,   0, 6, 0, 0);
        run("reset_dwell",300,  400,  25,   3, 1,   1,   0, 0, 5, 0);
        run("after_reset",300,  400,  25,   3, 0,   1,   0, 0, 0, 0);
        run("flat_cont",   77,   77,   3,   1, 1,   0,  20, 0, 0, 0);
        run("top_edge",  4000, 4095,4095,   1, 0,   1,   0, 0, 0, 0);
        run("floor_cont",   0,   50,  30,   0, 1,   0,  30, 0, 0, 0);
        run("stop_load",   10,   90,  20,   2, 1,   1,   2, 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            fs = int'($urandom_range(0, 4095));
            fe = fs + int'($urandom_range(0, 150));
            if (fe > 4095) fe = 4095;
            st = int'($urandom_range(1, 60));
            dw = int'($urandom_range(0, 3));
            cn = int'($urandom_range(0, 1));
            if (r % 7 == 6) st = 0;
            if (r % 11 == 10 && fe > fs) begin
                ks = fs; fs = fe; fe = ks;
            end
            ks = (cn != 0) ? int'($urandom_range(2, 50)) : 0;
            run("random", fs, fe, st, dw, cn, int'($urandom_range(0, 1)), ks, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_sweep_ctrl.md
# cordic_sweep_ctrl

Sweep sequencer for the 12-bit angle-CORDIC tone generator. It steps the generator's `freq` control word through a programmed range with a fixed dwell per step, in one-shot or continuous triangle mode, and drives `waveform_sel`. It sits at the PMOD top level between the configuration inputs (switches or register file) and the CORDIC, PWM and VGA datapath, replacing the static `freq` and `waveform_sel` connections.

## Interface
- `FREQ_W`, 12: width of the frequency control word; matches the CORDIC `freq_width`.
- `DWELL_W`, 24: width of the dwell count, in clock cycles.
- `clk1`  in  1: system clock, single domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request to begin a sweep. Honoured only in IDLE.
- `stop`  in  1: abort request. Honoured in any non-IDLE state.
- `f_start`  in  FREQ_W: first and lower frequency word.
- `f_stop`  in  FREQ_W: upper frequency word.
- `f_step`  in  FREQ_W: increment per step.
- `dwell`  in  DWELL_W: cycles spent in DWELL per step. A value of 0 is treated as 1.
- `cont`  in  1: 0 selects one-shot up-sweep; 1 selects continuous triangle sweep.
- `wave_cfg`  in  1: waveform select to apply during the sweep (1 = sine, 0 = cosine).
- `freq`  out  FREQ_W: registered frequency word to the CORDIC.
- `waveform_sel`  out  1: registered waveform select.
- `freq_tick`  out  1: one-cycle pulse on each cycle in which `freq` changes value.
- `busy`  out  1: high in LOAD, DWELL and STEP.
- `done`  out  1: one-cycle pulse when a sweep completes or is rejected.
- `err`  out  1: sticky config-error flag; cleared by the next accepted `start`.

## Operation
- **States:** IDLE, LOAD, DWELL, STEP, DONE.
- **IDLE:**
  - On `start`, with no `stop` in the same cycle:
    - If the config is valid, capture `f_start`, `f_stop`, `f_step`, `dwell`, `cont` and `wave_cfg` into shadow registers, clear `err`, and go to LOAD.
    - If the config is invalid (`f_step == 0` or `f_start > f_stop`), set `err`, go to DONE, and leave `freq` unchanged.
  - `start` and `stop` together in IDLE: `stop` wins and `start` is ignored.
- **LOAD (1 cycle):** `freq <= f_start`, `waveform_sel <= wave_cfg`, direction = up, dwell counter `<= max(dwell,1) - 1`. Go to DWELL.
- **DWELL:** decrement the counter. Go to STEP on the cycle the counter reads 0.
- **STEP (1 cycle):** compute on FREQ_W+1 bits (no wrap), then reload the dwell counter and return to DWELL, unless the sweep ends.
  - Direction up, `freq != f_stop`: `freq <= min(freq + f_step, f_stop)`.
  - Direction up, `freq == f_stop`:
    - `cont = 0`: go to DONE with `freq` held.
    - `cont = 1`: direction = down, `freq <= max(freq - f_step, f_start)`.
  - Direction down, `freq != f_start`: `freq <= max(freq - f_step, f_start)`.
  - Direction down, `freq == f_start`: direction = up, `freq <= min(freq + f_step, f_stop)`.
  - `cont = 1` with `f_start == f_stop`: `freq` stays constant, `freq_tick` stays low, and the sweep runs until `stop`.
- **DONE (1 cycle):** `done = 1`. Go to IDLE.
- **`stop`:** in LOAD, DWELL or STEP, go to IDLE on the next edge. No `done` pulse. `freq` and `waveform_sel` hold their current values, and no STEP update occurs in that cycle.
- **`start` while busy:** ignored. Shadow registers are not updated mid-sweep.
- **Reset mid-operation:** abandons the sweep immediately. All outputs return to reset values and the state returns to IDLE.

## Timing
- **Reset values:** `freq = 0`, `waveform_sel = 0`, `freq_tick = 0`, `busy = 0`, `done = 0`, `err = 0`, state IDLE, direction up.
- **Start latency:** `start` sampled at edge T. State is LOAD and `busy = 1` after T+1. `freq = f_start` after T+2.
- **Hold time:** every frequency value is held for exactly `max(dwell,1) + 1` cycles (DWELL cycles plus one STEP cycle). `freq_tick` is asserted in the same cycle `freq` shows the new value.
- **One-shot end:** `done` is high in the cycle after the final STEP. `busy` falls in that same cycle. IDLE follows on the next cycle.
- **Invalid config:** `err` and `done` both assert 2 cycles after `start` is sampled.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Package `cordic_ctrl_pkg`:**
  - State encoding constants: IDLE, LOAD, DWELL, STEP, DONE.
  - Direction constants: UP, DOWN.
  - Default widths `FREQ_W = 12` and `DWELL_W = 24`.
- **Sub-module `dwell_counter`:** load, decrement and zero flag, parameterised by DWELL_W.
- The FSM, shadow registers and saturating add/subtract stay in `cordic_sweep_ctrl`.

## Test plan
- `f_start = 100`, `f_stop = 130`, `f_step = 10`, `dwell = 4`, `cont = 0`: `freq` = 100, 110, 120, 130, each held 5 cycles. `done` pulses once, `busy` then falls, and `freq` stays 130.
- Same config with `cont = 1`: `freq` = 100, 110, 120, 130, 120, 110, 100, 110, … with no `done`. Then assert `stop`: IDLE the next cycle, `freq` frozen, no `done`.
- Clamp: `f_start = 100`, `f_stop = 125`, `f_step = 10`, `dwell = 0`: `freq` = 100, 110, 120, 125, each held 2 cycles, then `done`.
- Invalid: `f_step = 0` gives `err = 1` and `done` 2 cycles after `start`, `busy` never set, `freq` unchanged. A following valid `start` clears `err`.
- Pulse `start` mid-sweep: ignored and the sequence is unchanged. `start` and `stop` together in IDLE: no sweep starts.
- Assert `reset` during DWELL: the next cycle shows `freq = 0`, `busy = 0`, `waveform_sel = 0`, and a new `start` begins cleanly from `f_start`.
